truth_table_checker: RTL

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Sweeps a 3-bit stimulus {A,B,C} through 0..7. Each value is held for
//   SETTLE wait cycles plus one sample cycle. At the end of the sample cycle,
//   every channel's gate-level result is captured into a truth table and
//   compared against the behavioural result for the same channel.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-high reset, overrides start
//   start      : run one 8-vector sweep (accepted in IDLE only)
//   abc        : registered stimulus, A = bit 2, C = bit 0
//   out_struct : gate-level result per channel
//   out_comp   : behavioural result per channel
//   busy       : high while a sweep is in progress
//   done       : one-cycle pulse when a sweep completes
//   tt_struct  : captured table, bit ch*8+i = out_struct[ch] at abc = i
//   mismatch   : sticky per-channel disagreement flag for the last sweep
//   err_count  : number of disagreeing (vector, channel) pairs, saturating

// Per-channel capture: holds one 8-entry truth table and a sticky mismatch flag.
module truth_table_lane (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       cap,
   input  logic [2:0] idx,
   input  logic       s,
   input  logic       c,
   output logic [7:0] tt,
   output logic       mis
);
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tt  <= '0;
         mis <= 1'b0;
      end else if (cap) begin
         tt[idx] <= s;
         if (s ^ c) mis <= 1'b1;
      end
   end
endmodule

module truth_table_checker #(
   parameter int SETTLE = 2,
   parameter int NCH    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [2:0]       abc,
   input  logic [NCH-1:0]   out_struct,
   input  logic [NCH-1:0]   out_comp,
   output logic             busy,
   output logic             done,
   output logic [8*NCH-1:0] tt_struct,
   output logic [NCH-1:0]   mismatch,
   output logic [4:0]       err_count
);
   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

   // The counter counts down to zero, so loading SETTLE-1 gives exactly SETTLE WAIT cycles.
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] settle_cnt;
   logic       clr;
   logic       cap;
   logic [2:0] diff_cnt;
   logic [5:0] err_sum;

   assign clr = (state == IDLE) && start;
   assign cap = (state == SAMPLE);

   // Popcount of the channels that disagree on the current vector.
   always_comb begin
      diff_cnt = '0;
      for (int i = 0; i < NCH; i++)
         diff_cnt = diff_cnt + 3'(out_struct[i] ^ out_comp[i]);
   end

   assign err_sum = {1'b0, err_count} + {3'b000, diff_cnt};

   for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
      truth_table_lane u_lane (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .cap (cap),
         .idx (abc),
         .s   (out_struct[ch]),
         .c   (out_comp[ch]),
         .tt  (tt_struct[ch*8 +: 8]),
         .mis (mismatch[ch])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         abc        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         settle_cnt <= '0;
         err_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= WAIT;
                  abc        <= '0;
                  settle_cnt <= SETTLE_LD;
                  busy       <= 1'b1;
                  err_count  <= '0;
               end
            end
            WAIT: begin
               if (settle_cnt == 4'd0) state <= SAMPLE;
               else                    settle_cnt <= settle_cnt - 4'd1;
            end
            SAMPLE: begin
               err_count <= (err_sum > 6'd31) ? 5'd31 : err_sum[4:0];
               if (abc == 3'd7) begin
                  // The stimulus stays at 7 through DONE. It returns to 0 when the FSM re-enters IDLE.
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  abc        <= abc + 3'd1;
                  settle_cnt <= SETTLE_LD;
                  state      <= WAIT;
               end
            end
            DONE: begin
               done  <= 1'b0;
               abc   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
